fir_mac_param: RTL and testbench

Parametrised, time-multiplexed FIR filter. A single multiplier and accumulator process one tap per clock. It has a runtime-programmable coefficient bank, valid/ready handshakes on both the input and output streams, and rounding with saturation on the output. It sits in the sample datapath between a sample source and sink as the general-purpose successor to the fixed 16-tap, fixed-coefficient FIR.

---
 rtl/fir_mac_param.sv | 147 ++++++++++++++
 tb/tb_fir_mac_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_param.sv
// rtl/fir_mac_param.sv - time-multiplexed FIR, one tap per clock, programmable coefficients
// Single MAC walks the delay line after each accepted sample, then rounds and saturates.
module fir_mac_param #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 16,
   parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                     ck,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sat,
   input  logic                     coef_wr,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     coef_err
);

   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_W - 2);
   localparam logic signed [ACC_W-1:0] DMAX = ACC_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] DMIN = ~DMAX;

   logic [1:0]               state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [AW-1:0]            addr_q, addr_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;
   logic                     coef_err_q, coef_err_d;
   logic signed [DATA_W-1:0] samples_q [TAPS];
   logic signed [COEF_W-1:0] coef_q [TAPS];

   logic                     accept;
   logic                     coef_we;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  r;

   always_comb begin
      accept     = in_valid && (state_q == S_IDLE);
      coef_we    = coef_wr && (state_q == S_IDLE) && (32'(coef_addr) < TAPS);
      prod       = PW'(samples_q[addr_q]) * PW'(coef_q[addr_q]);
      prod_ext   = ACC_W'(prod);
      sum        = acc_q + HALF;
      r          = sum >>> (COEF_W - 1);
      state_d    = state_q;
      acc_d      = acc_q;
      addr_d     = addr_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      coef_err_d = coef_wr && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d   = '0;
               addr_d  = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + prod_ext;
            if (addr_q == AW'(TAPS - 1)) begin
               state_d = S_ROUND;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         S_ROUND: begin
            if (r > DMAX) begin
               out_data_d = DMAX[DATA_W-1:0];
               out_sat_d  = 1'b1;
            end else if (r < DMIN) begin
               out_data_d = DMIN[DATA_W-1:0];
               out_sat_d  = 1'b1;
            end else begin
               out_data_d = r[DATA_W-1:0];
               out_sat_d  = 1'b0;
            end
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         addr_q     <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
         coef_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         addr_q     <= addr_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
         coef_err_q <= coef_err_d;
      end
   end

   // Delay line and coefficient bank change only in IDLE, so a MAC pass sees a frozen snapshot.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            samples_q[i] <= '0;
            coef_q[i]    <= '0;
         end
      end else begin
         if (accept) begin
            samples_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
               samples_q[i] <= samples_q[i-1];
            end
         end
         if (coef_we) begin
            coef_q[coef_addr] <= coef_data;
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_mac_param.sv
// tb/tb_fir_mac_param.sv - directed vector bench for fir_mac_param
module tb_fir_mac_param;

   logic               ck;
   logic               rst_n;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_sat;
   logic               coef_wr;
   logic [3:0]         coef_addr;
   logic signed [15:0] coef_data;
   logic               coef_err;

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;

   fir_mac_param dut (
      .ck(ck), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
      .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   always @(posedge ck) if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;

   typedef struct {
      int          grp;
      logic [15:0] din;
      logic [15:0] dout;
      logic        sat;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge ck);
      rst_n = 1'b0;
      @(negedge ck);
      rst_n = 1'b1;
   endtask

   task automatic wr_coef(input int a, input int d);
      @(negedge ck);
      coef_wr = 1'b1; coef_addr = 4'(a); coef_data = 16'(d);
      @(negedge ck);
      coef_wr = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge ck); #1;
         lat++;
      end
   endtask

   task automatic send(input logic [15:0] d, output logic signed [15:0] q, output logic s, output int lat);
      int n;
      @(negedge ck);
      in_data = d; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge ck);
         n++;
      end
      @(posedge ck); #1;
      in_valid = 1'b0;
      wait_out(lat);
      q = out_data; s = out_sat;
      @(posedge ck); #1;
   endtask

   initial begin
      logic signed [15:0] q;
      logic s;
      int lat;
      int base;
      logic signed [15:0] held;

      for (int k = 0; k < 21; k++)
         tbl.push_back('{0, (k == 0) ? 16'sd16384 : 16'sd0, (k < 16) ? 16'(500 * (k + 1)) : 16'd0, 1'b0});
      tbl.push_back('{1, 16'sd16384, 16'sd1, 1'b0});
      tbl.push_back('{1, 16'sd16383, 16'sd0, 1'b0});
      tbl.push_back('{1, -16'sd16384, 16'sd0, 1'b0});
      for (int k = 0; k < 16; k++)
         tbl.push_back('{2, 16'sd32767, (k == 0) ? 16'sd32766 : 16'sd32767, k != 0});
      for (int j = 1; j <= 16; j++)
         tbl.push_back('{2, -16'sd32768, (j < 8) ? 16'sd32767 : (j == 8) ? -16'sd8 : -16'sd32768, j != 8});

      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
      #12;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_sat", out_sat, 0);
      chk("reset coef_err", coef_err, 0);
      @(negedge ck);
      rst_n = 1'b1;

      for (int g = 0; g < 3; g++) begin
         do_reset();
         for (int i = 0; i < 16; i++) begin
            if (g == 0) wr_coef(i, 1000 * (i + 1));
            else if (g == 2) wr_coef(i, 32767);
         end
         if (g == 1) wr_coef(0, 1);
         for (int v = 0; v < tbl.size(); v++) begin
            if (tbl[v].grp == g) begin
               send(tbl[v].din, q, s, lat);
               chk($sformatf("grp%0d vec%0d data", g, v), q, $signed(tbl[v].dout));
               chk($sformatf("grp%0d vec%0d sat", g, v), s, tbl[v].sat);
               chk($sformatf("grp%0d vec%0d latency", g, v), lat, 17);
            end
         end
      end

      // coefficient write in the same cycle as an accept applies to that sample
      do_reset();
      @(negedge ck);
      coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 16'sd1000;
      in_data = 16'sd16384; in_valid = 1'b1;
      @(posedge ck); #1;
      coef_wr = 1'b0; in_valid = 1'b0;
      chk("same-cycle wr coef_err", coef_err, 0);
      wait_out(lat);
      chk("same-cycle wr data", out_data, 500);
      @(posedge ck); #1;

      // backpressure: output held, nothing accepted, next sample one cycle after release
      do_reset();
      for (int i = 0; i < 16; i++) wr_coef(i, 1000 * (i + 1));
      out_ready = 1'b0;
      @(negedge ck);
      in_data = 16'sd16384; in_valid = 1'b1;
      @(posedge ck); #1;
      in_data = 16'sd0;
      wait_out(lat);
      chk("bp latency", lat, 17);
      held = out_data;
      base = acc_cnt;
      chk("bp first data", held, 500);
      for (int c = 0; c < 10; c++) begin
         @(posedge ck); #1;
         chk($sformatf("bp hold data c%0d", c), out_data, held);
         chk($sformatf("bp hold valid c%0d", c), out_valid, 1);
         chk($sformatf("bp in_ready c%0d", c), in_ready, 0);
      end
      chk("bp no accept", acc_cnt, base);
      @(negedge ck);
      out_ready = 1'b1;
      @(posedge ck); #1;
      chk("bp release in_ready", in_ready, 1);
      chk("bp release out_valid", out_valid, 0);
      @(posedge ck); #1;
      in_valid = 1'b0;
      chk("bp accept after release", acc_cnt, base + 1);
      chk("bp busy after accept", in_ready, 0);
      wait_out(lat);
      chk("bp second data", out_data, 1000);
      @(posedge ck); #1;

      // write during MAC is rejected and flagged for one cycle
      do_reset();
      for (int i = 0; i < 16; i++) wr_coef(i, 1000 * (i + 1));
      @(negedge ck);
      in_data = 16'sd16384; in_valid = 1'b1;
      @(posedge ck); #1;
      in_valid = 1'b0;
      @(negedge ck);
      coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 16'sd32767;
      @(posedge ck); #1;
      chk("wp coef_err pulse", coef_err, 1);
      @(negedge ck);
      coef_wr = 1'b0;
      @(posedge ck); #1;
      chk("wp coef_err cleared", coef_err, 0);
      wait_out(lat);
      chk("wp data", out_data, 500);
      @(posedge ck); #1;
      send(16'sd16384, q, s, lat);
      chk("wp coef unchanged", q, 1500);

      // reset during MAC aborts output and clears coefficients
      @(negedge ck);
      in_data = 16'sd16384; in_valid = 1'b1;
      @(posedge ck); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge ck);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst in_ready", in_ready, 1);
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst out_data", out_data, 0);
      chk("mid rst out_sat", out_sat, 0);
      chk("mid rst coef_err", coef_err, 0);
      @(negedge ck);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send((k == 0) ? 16'sd16384 : 16'sd0, q, s, lat);
         chk($sformatf("post rst data k%0d", k), q, 0);
         chk($sformatf("post rst latency k%0d", k), lat, 17);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
